// File: rtl/parity_count_arbiter_pkg.sv
// Shared types for the parity-tagged count arbiter: FSM encoding and
// parity tag values.
package parity_count_pkg;

  // ZERO is the one-cycle grant state for a zero-length burst.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ZERO  = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_count_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational: a sole requester
// wins outright; on a tie the requester that was not served last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_id,
  output logic win_id,
  output logic win_valid
);

  assign win_valid = req0 | req1;
  assign win_id    = (req0 & req1) ? ~last_id : req1;

endmodule

// File: rtl/parity_count_arbiter.sv
// Shares one wrapping count between two requesters. Each granted burst
// streams {count, parity} beats over valid/ready. The count persists
// across bursts and only clears on reset or cnt_clr while idle.
import parity_count_pkg::*;

module parity_count_arbiter #(
  parameter int CW = 3,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          par0,
  input  logic [LW-1:0] len0,
  input  logic          req1,
  input  logic          par1,
  input  logic [LW-1:0] len1,
  input  logic          cnt_clr,
  output logic          gnt0,
  output logic          gnt1,
  output logic [CW:0]   out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_id,
  output logic          out_last,
  output logic          busy
);

  state_t        state;
  logic [CW-1:0] count;
  logic [LW-1:0] remaining;
  logic          par_l;
  logic          owner;
  logic          last_id;
  logic          win_id;
  logic          win_valid;
  logic          par_w;
  logic [LW-1:0] len_w;

  rr_arb2 u_arb (
    .req0      (req0),
    .req1      (req1),
    .last_id   (last_id),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  // Parameters of whichever requester the arbiter currently favours.
  assign par_w = win_id ? par1 : par0;
  assign len_w = win_id ? len1 : len0;

  // Burst FSM: arbitrates in IDLE, streams beats in BURST, and owns the
  // shared count, the beat countdown and the grant pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      remaining <= '0;
      par_l     <= 1'b0;
      owner     <= 1'b0;
      last_id   <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (cnt_clr) count <= '0;
          if (win_valid) begin
            par_l     <= par_w;
            owner     <= win_id;
            last_id   <= win_id;
            remaining <= len_w;
            gnt0      <= ~win_id;
            gnt1      <= win_id;
            state     <= (len_w == '0) ? ZERO : BURST;
          end
        end
        ZERO: state <= IDLE;
        BURST: begin
          if (out_ready) begin
            count     <= count + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LW'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stream outputs decode straight from state flops, so they hold while
  // the consumer stalls and collapse to zero the moment reset asserts.
  assign out       = {count, par_l};
  assign out_id    = owner;
  assign out_valid = (state == BURST);
  assign out_last  = (state == BURST) && (remaining == LW'(1));
  assign busy      = (state != IDLE);

endmodule

// File: doc/parity_count_arbiter.md
Name: parity_count_arbiter

Overview:
- Shares one parity-tagged count generator between two requesters. Each requester asks for a burst of values of fixed parity (even or odd).
- A 2-way round-robin arbiter grants one burst at a time.
- The burst FSM emits values {count, parity} over a valid/ready stream.
- The shared count persists across bursts and wraps. It sits between requester logic and the count-value consumer.

Parameters:
- CW, 3, width of shared count; output value width is CW+1.
- LW, 4, width of burst-length fields.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- req0  in  1  requester 0 burst request; held until gnt0.
- par0  in  1  requester 0 parity bit (0 even, 1 odd).
- len0  in  LW  requester 0 burst length in beats.
- req1  in  1  requester 1 burst request.
- par1  in  1  requester 1 parity bit.
- len1  in  LW  requester 1 burst length.
- cnt_clr  in  1  synchronous clear of shared count; honoured in IDLE only.
- gnt0  out  1  one-cycle grant pulse to requester 0.
- gnt1  out  1  one-cycle grant pulse to requester 1.
- out  out  CW+1  output value {count, par}.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_id  out  1  owner of current beat.
- out_last  out  1  final beat of burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, count=0, remaining=0, out=0.
  - out_valid=0, out_last=0, out_id=0, gnt0=gnt1=0, busy=0.
  - rr pointer = last_id=1, so req0 wins the first tie.
- State IDLE:
  - out_valid=0.
  - If cnt_clr, count<=0.
  - If req0|req1, the arbiter picks the winner: the sole requester, or on a tie the one not equal to last_id.
  - On a win: latch par/len of the winner, last_id<=winner, gnt<winner><=1 next cycle.
  - Next state is BURST if latched len!=0. If len==0, the grant still pulses, no beats are emitted, and the FSM returns to IDLE.
  - A len==0 grant is a one-cycle ZERO state; busy=1 in ZERO.
- State BURST:
  - out_valid=1, out={count, par_l}, out_id=winner, out_last=(remaining==1).
  - The grant pulse coincides with the first BURST cycle. Request-to-first-valid latency is 1 cycle.
  - On out_valid&&out_ready: count<=count+1 (modulo 2^CW, 7->0 for CW=3) and remaining<=remaining-1.
  - On the out_last beat, the FSM goes to IDLE.
  - out, out_id and out_last are held stable while out_valid&&!out_ready.
  - cnt_clr is ignored in BURST.
- Requesters must drop req the cycle after seeing gnt. A req still high in IDLE is treated as a new request.
- Minimum one IDLE cycle between bursts.
- Request inputs are sampled only in IDLE. par/len changes during BURST are ignored.
- Reset mid-burst aborts immediately: no out_last, and count returns to 0.

Decomposition:
- Package parity_count_pkg: state encoding (IDLE, ZERO, BURST) and PAR_EVEN=0, PAR_ODD=1.
- One sub-module, rr_arb2: 2-request round-robin arbiter with a last_id input; combinational winner plus a valid output.
- The FSM, count and burst counter stay in the top module.

Test Plan:
- Reset, then req0=1 par0=0 len0=3 with out_ready=1 -> gnt0 pulses 1 cycle after the request; out=0,2,4 on consecutive cycles; out_last on the 4; out_id=0; busy falls after.
- req0 and req1 asserted together (par1=1, len=2 each) -> req0 served first with 0,2. After one IDLE cycle req1 is served with 5,7, count continuing from 2. A second tie then grants req1 first only if last_id=0.
- Backpressure: len=2, out_ready low for 3 cycles on beat 1 -> out/out_id/out_last stable; count advances only on accept.
- Wrap: count=6, par=1, len=3 -> out=13,15,1 (count 6,7,0).
- len=0 request -> gnt pulses, out_valid never rises, busy high for exactly one cycle, count unchanged.
- cnt_clr pulse in BURST -> ignored; cnt_clr in IDLE -> next burst starts at count 0.
- Reset asserted mid-burst -> all outputs 0 immediately; a new request afterwards starts at count 0.
